// File: rtl/step_clock_gen_pkg.sv
// Shared types and default timing for the step clock generator.
package step_clock_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE_HI = 2'd1,
        ST_PULSE_LO = 2'd2
    } state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_CLK_HIGH_CYCLES = 1000;
    localparam int unsigned DEF_CLK_LOW_CYCLES  = 1000;
    localparam int unsigned DEF_RUN_PERIOD      = 100_000_000;
    localparam int unsigned COUNT_W             = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/step_clock_gen_sync_debounce.sv
// Two-flop synchronizer followed by a stability-counter debouncer.
module step_clock_gen_sync_debounce
    import step_clock_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synced input agrees with the held level restarts the count.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/step_clock_gen.sv
// Pipeline clock source: debounced single-step button or periodic free-run pulses.
module step_clock_gen
    import step_clock_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CLK_HIGH_CYCLES = DEF_CLK_HIGH_CYCLES,
    parameter int unsigned CLK_LOW_CYCLES  = DEF_CLK_LOW_CYCLES,
    parameter int unsigned RUN_PERIOD      = DEF_RUN_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_step,
    input  logic                sw_run,
    output logic                cpu_clk,
    output logic                step_strobe,
    output logic [COUNT_W-1:0]  step_count,
    output logic                busy
);

    localparam int unsigned RUN_W  = $clog2(RUN_PERIOD + 1);
    localparam int unsigned PH_MAX = max_u(CLK_HIGH_CYCLES, CLK_LOW_CYCLES);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    logic               db_btn, db_run;
    logic               db_btn_q, db_btn_d;
    logic               press_q, press_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic               run_tick_c, trigger_c;
    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               cpu_clk_q, cpu_clk_d;
    logic               strobe_q, strobe_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               busy_q, busy_d;

    step_clock_gen_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_step),
        .dout (db_btn)
    );

    step_clock_gen_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk  (clk),
        .rst  (rst),
        .din  (sw_run),
        .dout (db_run)
    );

    always_comb begin
        db_btn_d   = db_btn;
        press_d    = db_btn & ~db_btn_q;
        run_tick_c = db_run && (run_cnt_q == RUN_W'(RUN_PERIOD - 1));
        run_cnt_d  = '0;
        if (db_run && !run_tick_c) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
        end
        trigger_c  = (press_q & ~db_run) | (run_tick_c & db_run);

        state_d    = state_q;
        phase_d    = phase_q;
        cpu_clk_d  = cpu_clk_q;
        strobe_d   = 1'b0;
        count_d    = count_q;

        // Triggers outside IDLE are dropped; a mode change only matters once back in IDLE.
        case (state_q)
            ST_IDLE: begin
                cpu_clk_d = 1'b0;
                if (trigger_c) begin
                    state_d   = ST_PULSE_HI;
                    phase_d   = PH_W'(CLK_HIGH_CYCLES - 1);
                    cpu_clk_d = 1'b1;
                    strobe_d  = 1'b1;
                    count_d   = count_q + COUNT_W'(1);
                end
            end
            ST_PULSE_HI: begin
                if (phase_q == '0) begin
                    state_d   = ST_PULSE_LO;
                    phase_d   = PH_W'(CLK_LOW_CYCLES - 1);
                    cpu_clk_d = 1'b0;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            ST_PULSE_LO: begin
                if (phase_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cpu_clk_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_btn_q  <= 1'b0;
            press_q   <= 1'b0;
            run_cnt_q <= '0;
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            cpu_clk_q <= 1'b0;
            strobe_q  <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            db_btn_q  <= db_btn_d;
            press_q   <= press_d;
            run_cnt_q <= run_cnt_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            cpu_clk_q <= cpu_clk_d;
            strobe_q  <= strobe_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
        end
    end

    assign cpu_clk     = cpu_clk_q;
    assign step_strobe = strobe_q;
    assign step_count  = count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Directed plus randomized bench for step_clock_gen against a sample-history model.
module tb_step_clock_gen;

    localparam int unsigned D = 4;
    localparam int unsigned H = 3;
    localparam int unsigned L = 2;
    localparam int unsigned P = 20;

    logic        clk = 1'b0;
    logic        rst, btn_step, sw_run;
    logic        cpu_clk, step_strobe, busy;
    logic [15:0] step_count;

    always #5 clk = ~clk;

    step_clock_gen #(
        .DEBOUNCE_CYCLES (D),
        .CLK_HIGH_CYCLES (H),
        .CLK_LOW_CYCLES  (L),
        .RUN_PERIOD      (P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_step    (btn_step),
        .sw_run      (sw_run),
        .cpu_clk     (cpu_clk),
        .step_strobe (step_strobe),
        .step_count  (step_count),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: raw sample histories, debounced level histories, cycles since last accepted step.
    bit [D+1:0]  hb, hr;
    bit [2:0]    dbb, dbr;
    int unsigned run_len;
    int unsigned t;
    bit          m_strobe;
    logic [15:0] m_count;

    // Level flips when the last D synced samples all disagree with it.
    function automatic bit deb(input bit [D+1:0] h, input bit db);
        bit flip;
        flip = 1'b1;
        for (int k = 2; k <= int'(D) + 1; k++) begin
            if (h[k] == db) flip = 1'b0;
        end
        return flip ? ~db : db;
    endfunction

    task automatic model_edge(input bit b, input bit r, input bit rs);
        bit press, tick, trig;
        if (rs) begin
            hb = '0; hr = '0; dbb = '0; dbr = '0;
            run_len = 0; t = H + L; m_strobe = 1'b0; m_count = 16'd0;
            return;
        end
        press = dbb[1] & ~dbb[2];
        tick  = dbr[0] && ((run_len % P) == P - 1);
        trig  = dbr[0] ? tick : press;
        if (t >= H + L && trig) begin
            t = 0;
            m_strobe = 1'b1;
            m_count = m_count + 16'd1;
        end else begin
            m_strobe = 1'b0;
            if (t < H + L) t = t + 1;
        end
        run_len = dbr[0] ? run_len + 1 : 0;
        hb  = {hb[D:0], b};
        hr  = {hr[D:0], r};
        dbb = {dbb[1:0], deb(hb, dbb[0])};
        dbr = {dbr[1:0], deb(hr, dbr[0])};
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit b, input bit r, input bit rs);
        btn_step = b;
        sw_run   = r;
        rst      = rs;
        @(posedge clk);
        model_edge(b, r, rs);
        #1;
        n_vec++;
        chk("cpu_clk",     16'(cpu_clk),     16'(t < H));
        chk("busy",        16'(busy),        16'(t < H + L));
        chk("step_strobe", 16'(step_strobe), 16'(m_strobe));
        chk("step_count",  step_count,       m_count);
    endtask

    initial begin
        int  rise;
        bit  found;
        bit  rb, rr;
        int  hold;

        btn_step = 1'b0; sw_run = 1'b0; rst = 1'b1;
        t = H + L; m_count = 16'd0;

        // Reset with the button held
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Clean press held 30 cycles: one pulse only
        rise = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (rise < 0 && cpu_clk === 1'b1) rise = i;
        end
        chk("press_latency", 16'(rise), 16'(D + 3));
        chk("count_after_press", step_count, 16'd1);
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // Bounce: toggles every 2 cycles never settle
        for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("count_after_bounce", step_count, 16'd1);

        // Free-run with button activity that must be ignored
        for (int i = 0; i < int'(D) + 104; i++) step((i % 16) < 8, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (cpu_clk === 1'b1) found = 1'b1;
        end
        chk("run_pulse_seen", 16'(found), 16'd1);
        repeat (30) step(1'b0, 1'b0, 1'b0);

        // Randomized button holds and mode flips
        rr = 1'b0;
        for (int i = 0; i < 60; i++) begin
            hold = int'($urandom_range(1, 12));
            rb   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rr = ~rr;
            repeat (hold) step(rb, rr, 1'b0);
        end
        repeat (30) step(1'b0, 1'b0, 1'b0);

        // Counter wrap from 0xFFFF
        force dut.count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        step(1'b0, 1'b0, 1'b0);
        release dut.count_q;
        repeat (12) step(1'b1, 1'b0, 1'b0);
        chk("count_wrap", step_count, 16'h0000);
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // Reset during PULSE_HI abandons the step
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (cpu_clk === 1'b1) found = 1'b1;
        end
        chk("second_press_seen", 16'(found), 16'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("rst_mid_cpu_clk", 16'(cpu_clk), 16'd0);
        chk("rst_mid_busy", 16'(busy), 16'd0);
        repeat (15) step(1'b0, 1'b0, 1'b0);
        chk("count_after_rst", step_count, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
